// File: rtl/modbus_uart_rx.sv
// modbus_uart_rx
// Oversampling (16x) UART receiver for the Modbus-to-Wishbone bridge. It
// deframes 8-bit characters (LSB first) with an optional even parity bit,
// parks each one in a one-deep holding register drained by the bridge, and
// flags the Modbus RTU inter-frame gap as a one-cycle silence pulse.
//
// Ports:
//   i_clk           single clock domain
//   i_rst           asynchronous, active-high reset
//   i_rx            asynchronous serial line, idle high
//   o_data_out      [7:0] received byte, [8] framing error (stop bit low)
//   o_data_received holding register valid
//   i_receive_req   single-cycle consume strobe from the bridge
//   o_parity_error  parity mismatch for the held byte
//   o_overflow      sticky: a byte was dropped because the holder was full
//   o_silence       one-cycle end-of-frame gap pulse
module modbus_uart_rx #(
  parameter int unsigned DIVISOR      = 27,
  parameter bit          PARITY_EN    = 1'b1,
  parameter int unsigned SILENCE_BITS = 39
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [8:0] o_data_out,
  output logic       o_data_received,
  input  logic       i_receive_req,
  output logic       o_parity_error,
  output logic       o_overflow,
  output logic       o_silence
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(DIVISOR - 1);
  localparam logic [15:0] SIL_LAST = 16'(SILENCE_BITS - 1);
  localparam logic [15:0] SIL_FULL = 16'(SILENCE_BITS);

  // Odd number of ones -> 1; XOR with the received parity bit gives the error.
  function automatic logic f_xor8(input logic [7:0] d);
    return ^d;
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_sync1, r_sync2, r_rxs_d;
  logic [15:0] r_div;
  logic [3:0]  r_sub;
  logic [2:0]  r_bit;
  logic [7:0]  r_shift;
  logic        r_par_err;
  logic [8:0]  r_data_out;
  logic        r_valid;
  logic        r_perr_out;
  logic        r_ovf;
  logic        r_silence;
  logic        r_armed;
  logic [3:0]  r_idle_sub;
  logic [15:0] r_idle_cnt;

  logic w_rxs, w_tick, w_fall, w_sample, w_start_edge, w_stop_sample;
  logic w_load, w_consume, w_idle_count, w_gap_done;

  assign w_rxs         = r_sync2;
  assign w_tick        = (r_div == DIV_LAST);
  assign w_fall        = r_rxs_d & ~w_rxs;
  assign w_sample      = w_tick && (r_sub == 4'd7);
  assign w_start_edge  = (r_state == S_IDLE) && w_fall;
  assign w_stop_sample = (r_state == S_STOP) && w_sample;
  // The holder accepts a new byte when empty or when it is being drained this very edge.
  assign w_load        = w_stop_sample && (!r_valid || i_receive_req);
  assign w_consume     = i_receive_req && r_valid;
  assign w_idle_count  = (r_state == S_IDLE) && w_rxs && w_tick;
  assign w_gap_done    = w_idle_count && (r_idle_sub == 4'hF) && (r_idle_cnt == SIL_LAST);

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_rxs_d <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      r_rxs_d <= r_sync2;
    end
  end

  // Free-running oversample tick divider and sub-bit tick counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div <= 16'd0;
      r_sub <= 4'd0;
    end else begin
      r_div <= w_tick ? 16'd0 : r_div + 16'd1;
      if (w_start_edge) begin
        r_sub <= 4'd0;
      end else if (w_tick) begin
        r_sub <= r_sub + 4'd1;
      end else begin
        r_sub <= r_sub;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; every bit decision is taken at the mid-bit sample.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_fall) w_state_nxt = S_START;
        else        w_state_nxt = S_IDLE;
      end
      S_START: begin
        if (w_sample) w_state_nxt = w_rxs ? S_IDLE : S_DATA;
        else          w_state_nxt = S_START;
      end
      S_DATA: begin
        if (w_sample && (r_bit == 3'd7)) w_state_nxt = PARITY_EN ? S_PARITY : S_STOP;
        else                             w_state_nxt = S_DATA;
      end
      S_PARITY: begin
        if (w_sample) w_state_nxt = S_STOP;
        else          w_state_nxt = S_PARITY;
      end
      S_STOP: begin
        if (w_sample) w_state_nxt = S_IDLE;
        else          w_state_nxt = S_STOP;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Data shift register, bit index and parity check for the character in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bit     <= 3'd0;
      r_shift   <= 8'd0;
      r_par_err <= 1'b0;
    end else if ((r_state == S_START) && w_sample) begin
      r_bit     <= 3'd0;
      r_par_err <= 1'b0;
    end else if ((r_state == S_DATA) && w_sample) begin
      r_shift <= {w_rxs, r_shift[7:1]};
      r_bit   <= r_bit + 3'd1;
    end else if ((r_state == S_PARITY) && w_sample) begin
      r_par_err <= f_xor8(r_shift) ^ w_rxs;
    end else begin
      r_bit     <= r_bit;
      r_shift   <= r_shift;
      r_par_err <= r_par_err;
    end
  end

  // Holding register, valid flag and sticky overflow.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_data_out <= 9'd0;
      r_perr_out <= 1'b0;
      r_valid    <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_load) begin
        r_data_out <= {~w_rxs, r_shift};
        r_perr_out <= r_par_err;
        r_valid    <= 1'b1;
      end else if (w_consume) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= r_valid;
      end
      // A stop sample that cannot load implies no drain this edge.
      if (w_consume) begin
        r_ovf <= 1'b0;
      end else if (w_stop_sample && !w_load) begin
        r_ovf <= 1'b1;
      end else begin
        r_ovf <= r_ovf;
      end
    end
  end

  // Idle bit-period counter and one-shot silence pulse, re-armed by each byte.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idle_sub <= 4'd0;
      r_idle_cnt <= 16'd0;
      r_armed    <= 1'b0;
      r_silence  <= 1'b0;
    end else begin
      if (w_stop_sample || w_start_edge) begin
        r_idle_sub <= 4'd0;
        r_idle_cnt <= 16'd0;
      end else if (w_idle_count) begin
        r_idle_sub <= r_idle_sub + 4'd1;
        if ((r_idle_sub == 4'hF) && (r_idle_cnt != SIL_FULL)) begin
          r_idle_cnt <= r_idle_cnt + 16'd1;
        end else begin
          r_idle_cnt <= r_idle_cnt;
        end
      end else begin
        r_idle_sub <= r_idle_sub;
        r_idle_cnt <= r_idle_cnt;
      end
      if (w_stop_sample) begin
        r_armed <= 1'b1;
      end else if (w_gap_done) begin
        r_armed <= 1'b0;
      end else begin
        r_armed <= r_armed;
      end
      r_silence <= w_gap_done && r_armed;
    end
  end

  assign o_data_out      = r_data_out;
  assign o_data_received = r_valid;
  assign o_parity_error  = r_perr_out;
  assign o_overflow      = r_ovf;
  assign o_silence       = r_silence;

endmodule

// File: tb/tb_modbus_uart_rx.sv
// tb_modbus_uart_rx
// Self-checking bench for modbus_uart_rx at DIVISOR=2, PARITY_EN=1,
// SILENCE_BITS=39 (bit period 32 cycles). A frame-level model of the holding
// register (valid/data/parity/overflow) and of the silence pulse is updated
// once per character and compared against the DUT on every falling clock edge.
module tb_modbus_uart_rx;
  localparam int DIV = 2;
  localparam int BITP = 16 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       receive_req = 1'b0;
  logic [8:0] data_out;
  logic       data_received, parity_error, overflow, silence;

  modbus_uart_rx #(.DIVISOR(DIV), .PARITY_EN(1'b1), .SILENCE_BITS(39)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx(rx), .o_data_out(data_out),
    .o_data_received(data_received), .i_receive_req(receive_req),
    .o_parity_error(parity_error), .o_overflow(overflow), .o_silence(silence)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int req_cycle = -10;
  int lat = 339;
  int rise_cyc = -1;
  logic dr_prev = 1'b0;

  // model state
  bit       chk_en = 1'b0;
  bit       m_valid = 1'b0;
  logic [8:0] m_data = 9'd0;
  bit       m_perr = 1'b0;
  bit       m_ovf = 1'b0;
  bit       m_armed = 1'b0;
  int       sil_center = 0;
  int       sil_count = 0;

  // Cycle counter and the single driver of receive_req (high for the cycle after posedge req_cycle).
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    receive_req = (cyc == req_cycle);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, want, cyc);
    end
  endtask

  task automatic m_consume();
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovf = 1'b0;
    end
  endtask

  task automatic m_deliver(input logic [7:0] d, input logic p, input logic s);
    if (!m_valid) begin
      m_data = {~s, d};
      m_perr = (($countones(d) + int'(p)) % 2) == 1;
      m_valid = 1'b1;
    end else begin
      m_ovf = 1'b1;
    end
    m_armed = 1'b1;
    sil_center = cyc + 1239;
  endtask

  task automatic m_reset();
    m_valid = 1'b0; m_data = 9'd0; m_perr = 1'b0; m_ovf = 1'b0; m_armed = 1'b0;
  endtask

  // Records the edge at which data_received rises (latency measurement).
  always @(negedge clk) begin
    if (data_received && !dr_prev) rise_cyc = cyc;
    dr_prev = data_received;
  end

  // Per-cycle comparison of the DUT against the frame-level model.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("valid", 32'(data_received), 32'(m_valid));
      check("data", 32'(data_out), 32'(m_data));
      check("parity", 32'(parity_error), 32'(m_perr));
      check("overflow", 32'(overflow), 32'(m_ovf));
    end
    if (!rst) begin
      if (silence) begin
        sil_count++;
        checks++;
        if (!m_armed || cyc < sil_center - 32 || cyc > sil_center + 32) begin
          errors++;
          $display("FAIL silence_pulse at cycle %0d armed=%0d expected near %0d", cyc, m_armed, sil_center);
        end
        m_armed = 1'b0;
      end else if (m_armed && cyc > sil_center + 32) begin
        checks++;
        errors++;
        $display("FAIL silence_missing at cycle %0d expected near %0d", cyc, sil_center);
        m_armed = 1'b0;
      end
    end
  end

  // Drives start + data + parity (+ stop when nbits==11) with bit timing of BITP cycles.
  task automatic send(input logic [7:0] d, input logic p, input logic s,
                      input int nbits, input bit simul, output int t0);
    logic [10:0] fr;
    fr = {s, p, d, 1'b0};
    @(posedge clk); #2;
    if ((cyc % 2) != 0) begin @(posedge clk); #2; end
    t0 = cyc;
    if (simul) req_cycle = t0 + lat - 1;
    for (int i = 0; i < nbits && i < 10; i++) begin
      rx = fr[i];
      repeat (BITP) @(posedge clk);
      #2;
    end
    if (nbits == 11) begin
      rx = s;
      repeat (8) @(posedge clk);
      chk_en = 1'b0;
      repeat (20) @(posedge clk);
      #2;
      if (simul) m_consume();
      m_deliver(d, p, s);
      chk_en = 1'b1;
      repeat (4) @(posedge clk);
      #2;
      rx = 1'b1;
    end
  endtask

  task automatic consume();
    @(posedge clk); #2;
    req_cycle = cyc + 1;
    repeat (2) @(posedge clk);
    #2;
    m_consume();
  endtask

  initial begin
    int t0;
    int sb;
    logic [7:0] d;
    logic p, s;

    rst = 1'b1; rx = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_valid", 32'(data_received), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    check("rst_silence", 32'(silence), 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Idle after reset alone: no silence pulse.
    repeat (1400) @(posedge clk);
    #2;
    check("no_silence_after_reset", 32'(sil_count), 32'd0);

    // 0x37, correct parity.
    rise_cyc = -1;
    send(8'h37, 1'b1, 1'b1, 11, 1'b0, t0);
    lat = rise_cyc - t0;
    check("latency_in_range", 32'(lat >= 335 && lat <= 343), 32'd1);
    check("b37_valid", 32'(data_received), 32'd1);
    check("b37_data", 32'(data_out), 32'h037);
    check("b37_perr", 32'(parity_error), 32'd0);
    consume();
    check("b37_consumed", 32'(data_received), 32'd0);

    // 0xA5 with wrong parity bit.
    send(8'hA5, 1'b1, 1'b1, 11, 1'b0, t0);
    check("bA5_data", 32'(data_out[7:0]), 32'hA5);
    check("bA5_perr", 32'(parity_error), 32'd1);
    consume();

    // 0x01 with stop bit low: framing error.
    send(8'h01, 1'b1, 1'b0, 11, 1'b0, t0);
    check("b01_frame", 32'(data_out), 32'h101);
    consume();

    // Overflow: second byte dropped, first retained.
    send(8'h01, 1'b1, 1'b1, 11, 1'b0, t0);
    send(8'h00, 1'b0, 1'b1, 11, 1'b0, t0);
    check("ovf_data", 32'(data_out), 32'h001);
    check("ovf_set", 32'(overflow), 32'd1);
    consume();
    check("ovf_cleared", 32'(overflow), 32'd0);
    check("ovf_valid_cleared", 32'(data_received), 32'd0);

    // receiveReq exactly on the stop-sample edge of the second byte.
    send(8'h11, 1'b0, 1'b1, 11, 1'b0, t0);
    send(8'h22, 1'b0, 1'b1, 11, 1'b1, t0);
    check("simul_data", 32'(data_out), 32'h022);
    check("simul_valid", 32'(data_received), 32'd1);
    check("simul_ovf", 32'(overflow), 32'd0);
    consume();

    // 0xFF then long idle: exactly one silence pulse.
    send(8'hFF, 1'b0, 1'b1, 11, 1'b0, t0);
    consume();
    sb = sil_count;
    repeat (1350) @(posedge clk);
    #2;
    check("silence_one_pulse", 32'(sil_count - sb), 32'd1);
    repeat (1400) @(posedge clk);
    #2;
    check("silence_no_second", 32'(sil_count - sb), 32'd1);

    // Short low glitch: no byte.
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rx = 1'b1;
    repeat (400) @(posedge clk);
    #2;
    check("glitch_no_byte", 32'(data_received), 32'd0);

    // Reset during bit 4 of a character, with a byte already held.
    send(8'h3C, 1'b0, 1'b1, 11, 1'b0, t0);
    send(8'h96, 1'b0, 1'b1, 5, 1'b0, t0);
    rx = 1'b0;
    repeat (16) @(posedge clk);
    #2;
    rst = 1'b1; chk_en = 1'b0; rx = 1'b1;
    m_reset();
    repeat (3) @(posedge clk);
    #2;
    check("midrst_data", 32'(data_out), 32'h0);
    check("midrst_valid", 32'(data_received), 32'h0);
    check("midrst_perr", 32'(parity_error), 32'h0);
    check("midrst_ovf", 32'(overflow), 32'h0);
    rst = 1'b0;
    chk_en = 1'b1;
    repeat (40) @(posedge clk);
    send(8'h5A, 1'b0, 1'b1, 11, 1'b0, t0);
    check("after_rst_data", 32'(data_out), 32'h05A);
    check("after_rst_perr", 32'(parity_error), 32'd0);
    consume();

    // Randomized traffic against the model.
    for (int n = 0; n < 40; n++) begin
      d = 8'($urandom);
      p = logic'(($countones(d) % 2) == 1) ^ logic'($urandom_range(0, 3) == 0);
      s = logic'($urandom_range(0, 5) != 0);
      send(d, p, s, 11, 1'b0, t0);
      if ($urandom_range(0, 1) == 1) consume();
      repeat ($urandom_range(2, 60)) @(posedge clk);
    end
    sb = sil_count;
    repeat (1500) @(posedge clk);
    #2;
    check("random_silence", 32'(sil_count - sb), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/modbus_uart_rx.md
# modbus_uart_rx

Serial receiver feeding the Modbus-to-Wishbone bridge. It oversamples the RS-485/UART line 16× and deframes 8-bit characters with optional even parity. Each character goes into a one-deep holding register that the bridge drains through the `dataReceived`/`receiveReq` handshake. The block also signals the Modbus RTU inter-frame gap as a `silence` pulse.

## Interface
- `DIVISOR`, 27: `clk` cycles per oversample tick; bit period = 16·DIVISOR cycles. Legal range 1–65535.
- `PARITY_EN`, 1: 1 = even parity bit after data; 0 = no parity bit.
- `SILENCE_BITS`, 39: idle bit periods after a stop bit that constitute a frame gap (≈3.5 chars of 11 bits).

Ports:
- `clk` in 1: single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `rx` in 1: asynchronous serial line, idle high.
- `dataOut` out 9: [7:0] received byte, [8] framing error (stop bit sampled low).
- `dataReceived` out 1: holding register valid.
- `receiveReq` in 1: single-cycle consume strobe from the bridge.
- `parityError` out 1: parity mismatch for the byte in the holding register.
- `overflow` out 1: sticky, a byte was dropped because the holding register was full.
- `silence` out 1: one-cycle pulse marking the end-of-frame gap.

## Operation
- `rx` passes through a 2-flop synchroniser; all logic below uses the synchronised `rxs`.
- Tick generator: counter 0..DIVISOR-1, `tick` on wrap. Free-running; it is not resynchronised to the start edge.
- Sub-bit counter `sub` (4 bit), counted in ticks. The sample point is `sub`==7.
- FSM states and transitions:
  - IDLE: on a high→low edge of `rxs`, clear `sub` → START.
  - START: at the sample point, `rxs` low → DATA with bit index 0; `rxs` high → IDLE (false start, nothing reported).
  - DATA: sample 8 bits LSB first, one per 16 ticks. After bit 7 → PARITY if PARITY_EN, else → STOP.
  - PARITY: sample the parity bit. Error = XOR of the 8 data bits and the parity bit is 1. → STOP.
  - STOP: sample the stop bit. Framing error = sampled 0. → IDLE immediately after the sample.
- Delivery at the stop sample:
  - If the holding register is empty, or `receiveReq` is high that same cycle, load the byte, the framing flag and `parityError`, and set `dataReceived`.
  - Otherwise discard the byte, keep the old contents and set `overflow`.
- Consume: `receiveReq` while `dataReceived`=1 clears `dataReceived` and `overflow`. `dataOut` and `parityError` hold their last values. `receiveReq` while empty is ignored.
- Silence detection:
  - The idle counter counts completed bit periods while in IDLE with `rxs` high.
  - It clears on the stop sample and on any start edge.
  - When the count reaches SILENCE_BITS, `silence` pulses once. It is armed again only by the next delivered or dropped byte.
  - No pulse occurs after reset until the first byte.

## Timing
- Reset values: `dataOut`=0, `dataReceived`=0, `parityError`=0, `overflow`=0, `silence`=0, FSM=IDLE, all counters 0, synchroniser flops=1.
- Reset mid-character abandons the character; nothing is delivered.
- `rx` falling edge to start detection: 2–3 `clk` cycles (synchroniser).
- `dataReceived` rises on the `clk` edge after the stop-bit sample tick. Total latency from the start-bit edge ≈ (9.5 + PARITY_EN)·16·DIVISOR + 3 cycles.
- `receiveReq` at edge N → `dataReceived`=0 after edge N. A new byte can load at edge N itself (simultaneous case).
- `silence` is high for exactly one `clk` cycle, SILENCE_BITS·16·DIVISOR cycles (±1 tick) after the stop sample.
- A glitch shorter than 8 ticks never produces a byte.

## Test plan
- DIVISOR=2, PARITY_EN=1: send 0x37 with parity 1 and stop 1 → `dataReceived`=1, `dataOut`=9'h037, `parityError`=0; pulse `receiveReq` → `dataReceived`=0 next cycle.
- Send 0xA5 with parity bit 1 → `dataOut`[7:0]=A5, `parityError`=1. Send 0x01 with stop bit 0 → `dataOut`=9'h101.
- Send 0x01 then 0x00 without `receiveReq` → `dataOut`=9'h001 retained, `overflow`=1; `receiveReq` → `overflow`=0.
- Assert `receiveReq` on the exact stop-sample cycle of a second byte → second byte loaded, `overflow` stays 0.
- Send 0xFF, then hold the line idle → one `silence` pulse after 39 bit periods (1248 cycles at DIVISOR=2, ±32), no second pulse. An idle line after reset alone gives no pulse.
- 4-cycle low glitch on `rx` gives no byte. Assert `rst` during bit 4 of a character → all outputs 0; the next full character is received correctly.
